ps2_keycode_rx: RTL and testbench



---
 rtl/ps2_keycode_rx.sv | 154 +++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the device clock, deframes
// 11-bit frames and folds E0/F0 prefixes into a 10-bit {break, ext, scan} code.
module ps2_keycode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] keycode,
    output logic       keycode_valid,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;
    state_t r_state, w_state_nxt;

    logic [1:0]    r_clk_sync, r_dat_sync;
    logic          r_clk_filt, r_clk_filt_d;
    logic [FW-1:0] r_filt_cnt;
    logic [3:0]    r_bitcnt;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_shift;
    logic          r_par, r_stop, r_brk, r_ext;
    logic          w_strobe, w_data, w_good;
    logic          w_err, w_load, w_set_ext, w_set_brk, w_clr_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    // Accept a new clock level only after it has held for FILTER_LEN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_MAX) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_strobe = r_clk_filt_d & ~r_clk_filt;
    assign w_data   = r_dat_sync[1];
    assign w_good   = (^{r_shift, r_par}) & r_stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_load      = 1'b0;
        w_set_ext   = 1'b0;
        w_set_brk   = 1'b0;
        w_clr_flags = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_strobe && !w_data) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_strobe) begin
                    if (r_bitcnt == 4'd9) w_state_nxt = S_CHECK;
                end else if (r_tcnt == TO_MAX) begin
                    w_err       = 1'b1;
                    w_clr_flags = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_IDLE;
                if (!w_good) begin
                    w_err       = 1'b1;
                    w_clr_flags = 1'b1;
                end else if (r_shift == 8'hE0) begin
                    w_set_ext = 1'b1;
                end else if (r_shift == 8'hF0) begin
                    w_set_brk = 1'b1;
                end else begin
                    w_load      = 1'b1;
                    w_clr_flags = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitcnt      <= '0;
            r_tcnt        <= '0;
            r_shift       <= '0;
            r_par         <= 1'b0;
            r_stop        <= 1'b0;
            r_brk         <= 1'b0;
            r_ext         <= 1'b0;
            keycode       <= '0;
            keycode_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            keycode_valid <= w_load;
            frame_err     <= w_err;
            if (w_load) keycode <= {r_brk, r_ext, r_shift};
            if (w_clr_flags) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else begin
                if (w_set_ext) r_ext <= 1'b1;
                if (w_set_brk) r_brk <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_strobe && !w_data) begin
                        r_bitcnt <= '0;
                        r_tcnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_strobe) begin
                        r_tcnt   <= '0;
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt < 4'd8)       r_shift[r_bitcnt[2:0]] <= w_data;
                        else if (r_bitcnt == 4'd8) r_par  <= w_data;
                        else                       r_stop <= w_data;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Randomized PS/2 frame bench: a frame-level model predicts each valid/error
// pulse, its code and its arrival cycle; one compare process checks every cycle.
module tb_ps2_keycode_rx;
    localparam int FILT = 8;
    localparam int TO   = 2000;
    localparam int LAT  = FILT + 4;  // sync(2) + filter + strobe->CHECK->output(2)

    logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [9:0] keycode;
    logic       keycode_valid, frame_err;

    ps2_keycode_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .keycode_valid(keycode_valid), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [9:0] code;
        int         cyc;
    } evt_t;

    evt_t       evq[$];
    evt_t       ce;
    int         cyc = 0;
    int         n_tests = 0, n_fail = 0;
    int         n_valid = 0, n_err = 0;
    logic [9:0] exp_kc = '0;
    bit         m_brk = 0, m_ext = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("reset keycode", keycode, 0);
            chk("reset valid", keycode_valid, 0);
            chk("reset err", frame_err, 0);
        end else begin
            if (keycode_valid && frame_err) begin
                chk("valid/err exclusive", 1, 0);
            end else if (keycode_valid || frame_err) begin
                if (keycode_valid) n_valid++;
                if (frame_err) n_err++;
                if (evq.size() == 0) begin
                    chk("unexpected pulse", {keycode_valid, frame_err}, 0);
                end else begin
                    ce = evq.pop_front();
                    chk("pulse kind err", frame_err, ce.is_err);
                    if (keycode_valid && !ce.is_err) begin
                        chk("pulse code", keycode, ce.code);
                        exp_kc = ce.code;
                    end
                    if (ce.cyc != 0) chk("pulse latency", cyc, ce.cyc);
                end
            end
            chk("keycode level", keycode, exp_kc);
        end
    end

    // One PS/2 bit: data set while clock high, then a low half-period.
    task automatic send_bit(input logic d, input int half, input bit glitch,
                            input bit push, input evt_t e);
        int g;
        ps2_data = d;
        if (glitch) begin
            g = $urandom_range(1, FILT - 1);
            repeat (13) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (g) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (half - 13 - g) @(negedge clk);
        end else begin
            repeat (half) @(negedge clk);
        end
        if (push) begin
            e.cyc = cyc + LAT;
            evq.push_back(e);
        end
        ps2_clk = 1'b0;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int half, input bit glitch);
        logic        par;
        logic [10:0] bits;
        evt_t        e;
        bit          has;
        par  = ~(^b) ^ bad_par;
        bits = {~bad_stop, par, b, 1'b0};
        has  = 0;
        e.is_err = 0; e.code = '0; e.cyc = 0;
        if (bad_par || bad_stop) begin
            has = 1; e.is_err = 1; m_brk = 0; m_ext = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            has = 1; e.code = {m_brk, m_ext, b}; m_brk = 0; m_ext = 0;
        end
        for (int i = 0; i < 11; i++) send_bit(bits[i], half, glitch, (i == 10) && has, e);
        ps2_data = 1'b1;
        repeat (30) @(negedge clk);
        chk("events drained", evq.size(), 0);
    endtask

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   v0, e0, r, half;
        evt_t te;
        logic [7:0] b;
        repeat (5) @(negedge clk);
        chk("lit reset keycode", keycode, 10'h000);
        chk("lit reset valid", keycode_valid, 1'b0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        v0 = n_valid; e0 = n_err;
        send_frame(8'h1D, 0, 0, 40, 0);
        chk("lit W make", keycode, 10'h01D);
        chk("lit W pulses", n_valid - v0, 1);
        chk("lit W errs", n_err - e0, 0);

        v0 = n_valid;
        send_frame(8'hF0, 0, 0, 40, 0);
        chk("lit F0 no pulse", n_valid - v0, 0);
        send_frame(8'h1D, 0, 0, 40, 0);
        chk("lit W break", keycode, 10'h21D);
        send_frame(8'h1C, 0, 0, 40, 0);
        chk("lit break cleared", keycode, 10'h01C);

        v0 = n_valid;
        send_frame(8'hE0, 0, 0, 30, 0);
        send_frame(8'hF0, 0, 0, 30, 0);
        send_frame(8'h75, 0, 0, 30, 0);
        chk("lit ext break", keycode, 10'h375);
        chk("lit ext break pulses", n_valid - v0, 1);

        v0 = n_valid; e0 = n_err;
        send_frame(8'h23, 1, 0, 30, 0);
        chk("lit parity err", n_err - e0, 1);
        chk("lit parity no valid", n_valid - v0, 0);
        chk("lit parity kc held", keycode, 10'h375);
        send_frame(8'h23, 0, 0, 30, 0);
        chk("lit after parity", keycode, 10'h023);

        // Prefix followed by a stalled frame: the timeout must also drop the prefix.
        send_frame(8'hF0, 0, 0, 30, 0);
        e0 = n_err;
        te.is_err = 1; te.code = '0; te.cyc = 0;
        send_bit(1'b0, 30, 0, 0, te);
        for (int i = 0; i < 5; i++) send_bit(i[0], 30, 0, 0, te);
        ps2_data = 1'b1;
        evq.push_back(te);
        m_brk = 0; m_ext = 0;
        repeat (TO + 100) @(negedge clk);
        chk("lit timeout err", n_err - e0, 1);
        chk("timeout drained", evq.size(), 0);
        send_frame(8'h1B, 0, 0, 30, 0);
        chk("lit after timeout", keycode, 10'h01B);

        send_frame(8'h1C, 0, 0, 40, 1);
        chk("lit glitch frame", keycode, 10'h01C);

        send_bit(1'b0, 30, 0, 0, te);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 30, 0, 0, te);
        @(posedge clk);
        rst = 1'b1;
        evq.delete();
        exp_kc = '0; m_brk = 0; m_ext = 0;
        repeat (3) @(negedge clk);
        chk("lit mid reset kc", keycode, 10'h000);
        rst = 1'b0;
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h5A, 0, 0, 30, 0);
        chk("lit after reset", keycode, 10'h05A);

        v0 = n_valid;
        send_frame(8'h1D, 0, 0, 25, 0);
        send_frame(8'h1D, 0, 0, 25, 0);
        chk("lit typematic pulses", n_valid - v0, 2);
        chk("lit typematic kc", keycode, 10'h01D);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else            b = 8'($urandom_range(0, 255));
            half = $urandom_range(20, 40);
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, half, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
